// File: rtl/delay_seq_pkg.sv
// Shared types and defaults for the delay step sequencer.
// Table entries pair a counter modulus with a repeat count.
package delay_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] module_v;
    logic [REP_W_DEF-1:0] reps;
  } entry_t;

endpackage

// File: rtl/delay_seq_table.sv
// Step table: DEPTH entries of {module, reps}.
// Synchronous write, combinational read, cleared on reset.
module delay_seq_table #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_module_i,
  input  logic [REP_W-1:0] wr_reps_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_module_o,
  output logic [REP_W-1:0] rd_reps_o
);

  logic [WIDTH-1:0] mod_q  [DEPTH];
  logic [REP_W-1:0] reps_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mod_q[i]  <= '0;
        reps_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mod_q[wr_addr_i]  <= wr_module_i;
      reps_q[wr_addr_i] <= wr_reps_i;
    end
  end

  assign rd_module_o = mod_q[rd_addr_i];
  assign rd_reps_o   = reps_q[rd_addr_i];

endmodule

// File: rtl/delay_sequencer.sv
// Walks the step table, reprogramming and enabling the attached
// delay counter, and counts its terminal pulses per step.
module delay_sequencer
  import delay_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_module,
  input  logic [REP_W-1:0] i_wr_reps,
  input  logic [AW-1:0]    i_last,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cnt,
  output logic [WIDTH-1:0] o_module,
  output logic             o_set_module_enbl,
  output logic             o_count_enbl,
  output logic             o_busy,
  output logic             o_step,
  output logic [AW-1:0]    o_step_idx,
  output logic             o_done
);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    last_q, last_d;
  logic [AW-1:0]    sidx_q, sidx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] rd_module;
  logic [REP_W-1:0] rd_reps;
  logic             wr_ok;

  // The table is frozen while a sequence runs.
  assign wr_ok = i_wr_en && (state_q == IDLE);

  delay_seq_table #(
    .WIDTH (WIDTH),
    .REP_W (REP_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk         (clk),
    .rst_i       (i_rst),
    .wr_en_i     (wr_ok),
    .wr_addr_i   (i_wr_addr),
    .wr_module_i (i_wr_module),
    .wr_reps_i   (i_wr_reps),
    .rd_addr_i   (idx_q),
    .rd_module_o (rd_module),
    .rd_reps_o   (rd_reps)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rep_d   = rep_q;
    sidx_d  = sidx_q;
    step_d  = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            last_d  = i_last;
            idx_d   = '0;
            rep_d   = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (rd_module == '0) begin
            if (idx_q == last_q) state_d = DONE;
            else idx_d = idx_q + 1'b1;
          end else begin
            rep_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (i_cnt) begin
            if (rep_q == rd_reps) begin
              step_d = 1'b1;
              sidx_d = idx_q;
              if (idx_q == last_q) begin
                state_d = DONE;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = LOAD;
              end
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      sidx_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      sidx_q  <= sidx_d;
      step_q  <= step_d;
    end
  end

  assign o_busy            = (state_q != IDLE);
  assign o_set_module_enbl = (state_q == LOAD) && (rd_module != '0);
  assign o_count_enbl      = (state_q == RUN);
  assign o_done            = (state_q == DONE);
  assign o_step            = step_q;
  assign o_module          = ((state_q == LOAD) || (state_q == RUN))
                             ? rd_module : '0;
  assign o_step_idx        = step_q ? sidx_q : (o_busy ? idx_q : '0);

endmodule
